led_pwm_sequencer: RTL and testbench

Controller for the team's single-channel PWM LED datapath. Owns the PWM period counter and compare stage and schedules the duty value period by period. It implements four LED patterns: off, fixed level, breathe (ramp up, hold, ramp down, hold) and blink. Configuration is taken from a top-level register interface and applied only on period boundaries, so the LED output never glitches mid-period.

---
 rtl/led_pwm_pkg.sv | 21 ++
 rtl/led_pwm_sequencer_if.sv | 14 +
 rtl/led_pwm_sequencer_pwm_core.sv | 29 ++
 rtl/led_pwm_sequencer.sv | 170 +++++++++++++++++
 tb/tb_led_pwm_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared encodings and default widths for the LED PWM sequencer
package led_pwm_pkg;
    localparam int CNT_W_DEF  = 6;
    localparam int HOLD_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIXED   = 3'd1,
        ST_UP      = 3'd2,
        ST_HOLD_HI = 3'd3,
        ST_DOWN    = 3'd4,
        ST_HOLD_LO = 3'd5
    } state_e;
endpackage

// File: rtl/led_pwm_sequencer_if.sv
// rtl/led_pwm_sequencer_if.sv - configuration bus from the register block to the sequencer
interface led_pwm_sequencer_if #(
    parameter int CNT_W  = led_pwm_pkg::CNT_W_DEF,
    parameter int HOLD_W = led_pwm_pkg::HOLD_W_DEF
) ();
    logic              cfg_load;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  level;
    logic [2:0]        step;
    logic [HOLD_W-1:0] hold;

    modport master (output cfg_load, mode, level, step, hold);
    modport slave  (input  cfg_load, mode, level, step, hold);
endinterface

// File: rtl/led_pwm_sequencer_pwm_core.sv
// rtl/led_pwm_sequencer_pwm_core.sv - period counter, registered compare and period markers
module pwm_core #(
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm,
    output logic             o_period_start,
    output logic             o_boundary
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_pwm;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            r_pwm <= (r_cnt < i_duty);
        end
    end

    // Gated by reset so the marker stays low while held, yet is high on the first free-running cycle.
    assign o_period_start = (r_cnt == '0) && !i_reset;
    assign o_boundary     = (r_cnt == '1);
    assign o_pwm          = r_pwm;
endmodule

// File: rtl/led_pwm_sequencer.sv
// rtl/led_pwm_sequencer.sv - pattern FSM and config shadow scheduling the PWM duty per period
module led_pwm_sequencer
    import led_pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    led_pwm_sequencer_if.slave        cfg_if,
    output logic                      o_pwm,
    output logic [CNT_W-1:0]          o_duty,
    output logic                      o_period_start,
    output logic                      o_cfg_pending,
    output logic [2:0]                o_state
);
    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_duty, w_duty_nxt;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic              r_pending;
    mode_e             r_sh_mode, r_act_mode;
    logic [CNT_W-1:0]  r_sh_level, r_act_level;
    logic [2:0]        r_sh_step, r_act_step;
    logic [HOLD_W-1:0] r_sh_hold, r_act_hold;

    logic              w_boundary, w_apply;
    mode_e             w_mode;
    logic [CNT_W-1:0]  w_level, w_up, w_dn;
    logic [2:0]        w_step;
    logic [HOLD_W-1:0] w_hold;
    logic [CNT_W:0]    w_step_ext, w_sum;

    pwm_core #(.CNT_W(CNT_W)) u_core (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_duty         (r_duty),
        .o_pwm          (o_pwm),
        .o_period_start (o_period_start),
        .o_boundary     (w_boundary)
    );

    // Shadow wins only on the applying boundary; otherwise the active config drives the step.
    assign w_apply = w_boundary && r_pending;
    assign w_mode  = w_apply ? r_sh_mode  : r_act_mode;
    assign w_level = w_apply ? r_sh_level : r_act_level;
    assign w_step  = w_apply ? r_sh_step  : r_act_step;
    assign w_hold  = w_apply ? r_sh_hold  : r_act_hold;

    assign w_step_ext = (w_step == 3'd0) ? (CNT_W+1)'(1) : (CNT_W+1)'(w_step);
    assign w_sum      = {1'b0, r_duty} + w_step_ext;
    assign w_up       = (w_sum > {1'b0, w_level}) ? w_level : w_sum[CNT_W-1:0];
    assign w_dn       = ({1'b0, r_duty} > w_step_ext) ? (r_duty - w_step_ext[CNT_W-1:0]) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= 1'b0;
            r_sh_mode   <= MODE_OFF;
            r_sh_level  <= '0;
            r_sh_step   <= 3'd1;
            r_sh_hold   <= '0;
            r_act_mode  <= MODE_OFF;
            r_act_level <= '0;
            r_act_step  <= 3'd1;
            r_act_hold  <= '0;
        end else begin
            r_pending <= cfg_if.cfg_load || (r_pending && !w_apply);
            if (cfg_if.cfg_load) begin
                r_sh_mode  <= mode_e'(cfg_if.mode);
                r_sh_level <= cfg_if.level;
                r_sh_step  <= cfg_if.step;
                r_sh_hold  <= cfg_if.hold;
            end
            if (w_apply) begin
                r_act_mode  <= r_sh_mode;
                r_act_level <= r_sh_level;
                r_act_step  <= r_sh_step;
                r_act_hold  <= r_sh_hold;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_hold_nxt  = r_hold_cnt;
        if (w_boundary) begin
            if (w_apply && (w_mode != r_act_mode)) begin
                case (w_mode)
                    MODE_OFF:     begin w_state_nxt = ST_IDLE;    w_duty_nxt = '0;      end
                    MODE_FIXED:   begin w_state_nxt = ST_FIXED;   w_duty_nxt = w_level; end
                    MODE_BREATHE: begin w_state_nxt = ST_UP;      w_duty_nxt = '0;      end
                    default: begin
                        w_state_nxt = ST_HOLD_HI;
                        w_duty_nxt  = w_level;
                        w_hold_nxt  = w_hold;
                    end
                endcase
            end else if (w_apply && (w_mode == MODE_BREATHE) && (r_duty > w_level) &&
                         ((r_state == ST_UP) || (r_state == ST_HOLD_HI))) begin
                w_state_nxt = ST_HOLD_HI;
                w_duty_nxt  = w_level;
                w_hold_nxt  = w_hold;
            end else begin
                case (r_state)
                    ST_IDLE:  w_duty_nxt = '0;
                    ST_FIXED: w_duty_nxt = w_level;
                    ST_UP: begin
                        w_duty_nxt = w_up;
                        if (w_up == w_level) begin
                            w_state_nxt = ST_HOLD_HI;
                            w_hold_nxt  = w_hold;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (w_mode == MODE_BLINK) w_duty_nxt = w_level;
                        if (r_hold_cnt != '0) begin
                            w_hold_nxt = r_hold_cnt - 1'b1;
                        end else if (w_mode == MODE_BREATHE) begin
                            w_state_nxt = ST_DOWN;
                        end else begin
                            w_state_nxt = ST_HOLD_LO;
                            w_duty_nxt  = '0;
                            w_hold_nxt  = w_hold;
                        end
                    end
                    ST_DOWN: begin
                        w_duty_nxt = w_dn;
                        if (w_dn == '0) begin
                            w_state_nxt = ST_HOLD_LO;
                            w_hold_nxt  = w_hold;
                        end
                    end
                    ST_HOLD_LO: begin
                        if (r_hold_cnt != '0) begin
                            w_hold_nxt = r_hold_cnt - 1'b1;
                        end else if (w_mode == MODE_BREATHE) begin
                            w_state_nxt = ST_UP;
                        end else begin
                            w_state_nxt = ST_HOLD_HI;
                            w_duty_nxt  = w_level;
                            w_hold_nxt  = w_hold;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_duty_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        o_state       = r_state;
        o_duty        = r_duty;
        o_cfg_pending = r_pending;
    end
endmodule

// File: tb/tb_led_pwm_sequencer.sv
// tb/tb_led_pwm_sequencer.sv - directed and randomized period-level checks of the LED PWM sequencer
module tb_led_pwm_sequencer;
    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] level;
        logic [2:0] step;
        logic [3:0] hold;
    } cfg_t;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       o_pwm, o_period_start, o_cfg_pending;
    logic [5:0] o_duty;
    logic [2:0] o_state;

    int   total = 0;
    int   bad   = 0;
    int   pat_duty[$];
    int   pat_state[$];
    int   pidx, hh_start;
    cfg_t act_cfg, sh_cfg, none;
    bit   pend;

    led_pwm_sequencer_if #(.CNT_W(6), .HOLD_W(4)) cfg_if ();

    led_pwm_sequencer #(.CNT_W(6), .HOLD_W(4)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .cfg_if         (cfg_if),
        .o_pwm          (o_pwm),
        .o_duty         (o_duty),
        .o_period_start (o_period_start),
        .o_cfg_pending  (o_cfg_pending),
        .o_state        (o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic cfg_t mk(input int m, input int l, input int s, input int h);
        cfg_t c;
        c.mode = m[1:0]; c.level = l[5:0]; c.step = s[2:0]; c.hold = h[3:0];
        return c;
    endfunction

    // One full repetition of the pattern, one entry per period: (duty, state).
    function automatic void build(input cfg_t c);
        int l = c.level;
        int s = (c.step == 0) ? 1 : c.step;
        int h1 = c.hold + 1;
        int d;
        pat_duty.delete(); pat_state.delete(); hh_start = 0;
        case (c.mode)
            2'd0: begin pat_duty.push_back(0); pat_state.push_back(0); end
            2'd1: begin pat_duty.push_back(l); pat_state.push_back(1); end
            2'd3: begin
                for (int i = 0; i < h1; i++) begin pat_duty.push_back(l); pat_state.push_back(3); end
                for (int i = 0; i < h1; i++) begin pat_duty.push_back(0); pat_state.push_back(5); end
            end
            default: begin
                d = 0;
                do begin
                    pat_duty.push_back(d); pat_state.push_back(2);
                    d = (d + s > l) ? l : d + s;
                end while (d < l);
                hh_start = pat_duty.size();
                for (int i = 0; i < h1; i++) begin pat_duty.push_back(l); pat_state.push_back(3); end
                d = l;
                do begin
                    pat_duty.push_back(d); pat_state.push_back(4);
                    d = (d > s) ? d - s : 0;
                end while (d > 0);
                for (int i = 0; i < h1; i++) begin pat_duty.push_back(0); pat_state.push_back(5); end
            end
        endcase
    endfunction

    function automatic void model_apply(input cfg_t c, input int cur_d, input int cur_s);
        build(c);
        if (c.mode == act_cfg.mode && c.mode == 2'd2 && (cur_s == 2 || cur_s == 3) && cur_d > int'(c.level))
            pidx = hh_start;
        else
            pidx = 0;
        act_cfg = c;
    endfunction

    function automatic void model_reset();
        act_cfg = mk(0, 0, 1, 0); sh_cfg = act_cfg; pend = 0;
        build(act_cfg); pidx = 0;
    endfunction

    task automatic drive(input cfg_t c);
        cfg_if.cfg_load = 1'b1;
        cfg_if.mode = c.mode; cfg_if.level = c.level; cfg_if.step = c.step; cfg_if.hold = c.hold;
    endtask

    // Runs one 64-cycle period from cnt==0, optionally strobing up to two configs (lpa < lpb).
    task automatic run_period(input int lpa, input cfg_t ca, input int lpb, input cfg_t cb);
        int hi = 0;
        logic [63:0] ps = '0;
        bit stable = 1;
        int ed = pat_duty[pidx];
        int es = pat_state[pidx];
        bit apply = pend;
        logic [5:0] d0 = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk); #1;
            if (k == 0) begin
                chk("duty", o_duty, ed);
                chk("state", o_state, es);
                chk("pending", o_cfg_pending, pend);
                d0 = o_duty;
            end else if (o_duty !== d0) begin
                stable = 0;
            end
            if (o_pwm === 1'b1) hi++;
            ps[k] = o_period_start;
            if (lpa >= 0 && lpa < 63 && k == lpa + 1) chk("pend_rise", o_cfg_pending, 1);
            cfg_if.cfg_load = 1'b0;
            if (k == lpa) drive(ca);
            if (k == lpb) drive(cb);
        end
        chk("pwm_high", hi, ed);
        chk("period_start", ps, 64'h1);
        chk("duty_stable", stable, 1);
        if (lpa >= 0 && lpa < 63) begin sh_cfg = ca; apply = 1; end
        if (lpb >= 0 && lpb < 63) begin sh_cfg = cb; apply = 1; end
        if (apply) begin
            model_apply(sh_cfg, ed, es);
            pend = 0;
        end else begin
            pidx = (pidx + 1) % pat_duty.size();
        end
        if (lpa == 63) begin sh_cfg = ca; pend = 1; end
        if (lpb == 63) begin sh_cfg = cb; pend = 1; end
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_period(-1, none, -1, none);
    endtask

    initial begin
        int m, n;
        none = mk(0, 0, 0, 0);
        i_reset = 1'b1;
        cfg_if.cfg_load = 1'b0; cfg_if.mode = '0; cfg_if.level = '0; cfg_if.step = '0; cfg_if.hold = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_state", o_state, 0);
        chk("rst_duty", o_duty, 0);
        chk("rst_pwm", o_pwm, 0);
        chk("rst_pending", o_cfg_pending, 0);
        chk("rst_pstart", o_period_start, 0);
        @(posedge clk); #1 i_reset = 1'b0;

        run_n(4);
        run_period(10, mk(1, 16, 0, 0), -1, none);
        run_n(3);
        run_period(30, mk(1, 30, 0, 0), -1, none);
        run_n(1);
        run_period(5, mk(2, 62, 1, 0), -1, none);
        run_n(130);
        run_period(20, mk(3, 40, 0, 2), -1, none);
        run_n(13);
        run_period(1, mk(0, 0, 0, 0), -1, none);
        run_n(1);
        run_period(7, mk(2, 10, 4, 1), -1, none);
        run_n(16);

        run_period(63, mk(1, 33, 0, 0), -1, none);
        run_period(-1, none, -1, none);
        run_n(2);

        run_period(8, mk(3, 20, 0, 1), 40, mk(2, 25, 2, 0));
        run_n(30);

        run_period(3, mk(0, 0, 0, 0), -1, none);
        run_period(4, mk(2, 50, 3, 1), -1, none);
        run_n(7);
        run_period(10, mk(2, 12, 2, 2), -1, none);
        run_n(20);

        for (int r = 0; r < 4; r++) begin
            do m = $urandom_range(1, 3); while (m == int'(act_cfg.mode));
            run_period($urandom_range(0, 62),
                       mk(m, $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3)),
                       -1, none);
            n = pat_duty.size() + 3;
            run_n(n > 40 ? 40 : n);
        end

        run_period(2, mk(0, 0, 0, 0), -1, none);
        run_period(2, mk(2, 63, 1, 0), -1, none);
        run_n(5);
        @(negedge clk); #1;
        drive(mk(1, 7, 0, 0));
        @(negedge clk); #1;
        cfg_if.cfg_load = 1'b0;
        chk("mid_pending", o_cfg_pending, 1);
        repeat (10) @(negedge clk);
        #1 i_reset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_state", o_state, 0);
        chk("mid_rst_duty", o_duty, 0);
        chk("mid_rst_pending", o_cfg_pending, 0);
        chk("mid_rst_pwm", o_pwm, 0);
        @(posedge clk); #1 i_reset = 1'b0;
        model_reset();
        run_n(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
